// File: rtl/ps2_pattern_ctl.sv
// ps2_pattern_ctl: decodes PS/2 Set-2 scan bytes into pattern commands on a
// WIDTH-bit LED register. Handles F0 break and E0 extended prefixes, suppresses
// typematic repeats of the held key, and steps the pattern on a timed auto-run.
module ps2_pattern_ctl #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [7:0]       KEY_LEFT  = 8'h1D,
  parameter logic [7:0]       KEY_RIGHT = 8'h22,
  parameter logic [7:0]       KEY_REV   = 8'h14,
  parameter logic [7:0]       KEY_AUTO  = 8'h29,
  parameter int unsigned      AUTO_DIV  = 5000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PS2_Done_Sig,
  input  logic [7:0]       PS2_Data,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Auto_Out,
  output logic             Dir_Out,
  output logic             Cmd_Pulse
);

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] EXT_LEFT   = 8'h6B;
  localparam logic [7:0] EXT_RIGHT  = 8'h74;

  localparam int unsigned   PW         = $clog2(AUTO_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BREAK,
    S_EXT_BREAK
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_REV,
    CMD_AUTO
  } cmd_e;

  state_e           r_state;
  logic [8:0]       r_held_key;     // {ext, code} of the key currently held down
  logic             r_held_valid;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_data;
  logic             r_auto;
  logic             r_dir;
  logic             r_cmd_pulse;

  logic             w_is_make;
  logic             w_is_release;
  logic [8:0]       w_key;
  cmd_e             w_cmd;
  logic             w_exec;
  logic             w_tick;
  logic             w_rel_match;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] d);
    return {d[WIDTH-2:0], d[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] d);
    return {d[0], d[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // Classify the strobed byte and decide whether a command executes this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_is_make    = 1'b0;
    w_is_release = 1'b0;
    w_cmd        = CMD_NONE;
    w_key        = {(r_state == S_EXT || r_state == S_EXT_BREAK), PS2_Data};

    if (PS2_Done_Sig && PS2_Data != BYTE_BREAK) begin
      if (r_state == S_IDLE || r_state == S_EXT)
        w_is_make = (PS2_Data != BYTE_EXT);
      else
        w_is_release = 1'b1;
    end

    if (r_state == S_EXT) begin
      if (PS2_Data == EXT_LEFT)       w_cmd = CMD_LEFT;
      else if (PS2_Data == EXT_RIGHT) w_cmd = CMD_RIGHT;
    end else begin
      if (PS2_Data == KEY_LEFT)       w_cmd = CMD_LEFT;
      else if (PS2_Data == KEY_RIGHT) w_cmd = CMD_RIGHT;
      else if (PS2_Data == KEY_REV)   w_cmd = CMD_REV;
      else if (PS2_Data == KEY_AUTO)  w_cmd = CMD_AUTO;
    end

    // A make matching the still-held key is a typematic repeat.
    w_exec      = w_is_make && (w_cmd != CMD_NONE) &&
                  !(r_held_valid && r_held_key == w_key);
    w_rel_match = w_is_release && r_held_valid && (r_held_key == w_key);
    w_tick      = r_auto && (r_presc == PRESC_LAST);
  end

  // Decoder FSM, held-key tracking, prescaler and pattern register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_held_key   <= '0;
      r_held_valid <= 1'b0;
      r_presc      <= '0;
      r_data       <= INIT;
      r_auto       <= 1'b0;
      r_dir        <= 1'b1;
      r_cmd_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order in this block.
      r_cmd_pulse <= w_exec;

      // Prefix tracking; a repeated prefix simply re-enters its prefix state.
      if (PS2_Done_Sig) begin
        unique case (r_state)
          S_IDLE:
            if (PS2_Data == BYTE_BREAK)    r_state <= S_BREAK;
            else if (PS2_Data == BYTE_EXT) r_state <= S_EXT;
          S_EXT:
            if (PS2_Data == BYTE_BREAK)    r_state <= S_EXT_BREAK;
            else if (PS2_Data != BYTE_EXT) r_state <= S_IDLE;
          S_BREAK:
            if (PS2_Data != BYTE_BREAK)    r_state <= S_IDLE;
          S_EXT_BREAK:
            if (PS2_Data != BYTE_BREAK)    r_state <= S_IDLE;
          default:                         r_state <= S_IDLE;
        endcase
      end

      if (w_exec) begin
        r_held_key   <= w_key;
        r_held_valid <= 1'b1;
      end else if (w_rel_match) begin
        r_held_valid <= 1'b0;
      end

      // Key commands restart the auto period, except a reverse that does not
      // coincide with a tick; the prescaler idles at zero while auto is off.
      if (w_exec && (w_cmd != CMD_REV || w_tick)) r_presc <= '0;
      else if (w_tick || !r_auto)                 r_presc <= '0;
      else                                        r_presc <= r_presc + 1'b1;

      // A key command takes priority over a coincident auto tick.
      if (w_exec) begin
        unique case (w_cmd)
          CMD_LEFT:  begin r_data <= rot_left(r_data);  r_dir <= 1'b1; end
          CMD_RIGHT: begin r_data <= rot_right(r_data); r_dir <= 1'b0; end
          CMD_REV:   r_data <= bit_rev(r_data);
          CMD_AUTO:  r_auto <= ~r_auto;
          default:   ;
        endcase
      end else if (w_tick) begin
        r_data <= r_dir ? rot_left(r_data) : rot_right(r_data);
      end
    end
  end

  assign Data_Out  = r_data;
  assign Auto_Out  = r_auto;
  assign Dir_Out   = r_dir;
  assign Cmd_Pulse = r_cmd_pulse;

endmodule

// File: tb/tb_ps2_pattern_ctl.sv
// tb_ps2_pattern_ctl: directed scan-byte sequences into two controllers that
// share stimulus but reset to different patterns. A byte-stream model predicts
// every output each cycle; literal checks pin the model to known results.
module tb_ps2_pattern_ctl;

  localparam int AUTO_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       done;
  logic [7:0] data;

  logic [7:0] data0, data1;
  logic       auto0, auto1, dir0, dir1, pulse0, pulse1;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 CLK = ~CLK;

  ps2_pattern_ctl #(.WIDTH(8), .INIT(8'h01), .AUTO_DIV(AUTO_DIV)) dut0 (
    .CLK(CLK), .RST(RST), .PS2_Done_Sig(done), .PS2_Data(data),
    .Data_Out(data0), .Auto_Out(auto0), .Dir_Out(dir0), .Cmd_Pulse(pulse0)
  );

  ps2_pattern_ctl #(.WIDTH(8), .INIT(8'h03), .AUTO_DIV(AUTO_DIV)) dut1 (
    .CLK(CLK), .RST(RST), .PS2_Done_Sig(done), .PS2_Data(data),
    .Data_Out(data1), .Auto_Out(auto1), .Dir_Out(dir1), .Cmd_Pulse(pulse1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending prefix bytes are kept as a queue; a sequence completes on the
  // first non-prefix byte. Auto ticks are derived from the edge index at
  // which the current auto period started.
  logic [7:0] m_data [2];
  bit         m_auto, m_dir, m_pulse, m_hv;
  int         m_held;
  int         cyc, anchor;
  byte unsigned pend[$];

  function automatic logic [7:0] m_rol(input logic [7:0] d);
    int v = d;
    return 8'((v * 2) % 256 + v / 128);
  endfunction

  function automatic logic [7:0] m_ror(input logic [7:0] d);
    int v = d;
    return 8'(v / 2 + (v % 2) * 128);
  endfunction

  function automatic logic [7:0] m_rev(input logic [7:0] d);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = d[i];
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    bit has_e, has_f, tick, exec;
    int key, cmd;
    if (RST) begin
      m_data[0] = 8'h01; m_data[1] = 8'h03;
      m_auto = 0; m_dir = 1; m_pulse = 0; m_hv = 0; m_held = 0;
      cyc = 0; anchor = 0; pend.delete();
    end else begin
      tick = m_auto && ((cyc - anchor) % AUTO_DIV == AUTO_DIV - 1);
      exec = 0; cmd = 0;
      if (done) begin
        has_e = 0; has_f = 0;
        foreach (pend[i]) begin
          if (pend[i] == 8'hE0) has_e = 1;
          if (pend[i] == 8'hF0) has_f = 1;
        end
        if (data == 8'hF0) begin
          if (!has_f) pend.push_back(8'hF0);
        end else if (data == 8'hE0 && !has_f) begin
          pend.delete(); pend.push_back(8'hE0);
        end else begin
          key = (has_e ? 256 : 0) + data;
          if (has_f) begin
            if (m_hv && m_held == key) m_hv = 0;
          end else begin
            case (key)
              'h01D: cmd = 1;  'h022: cmd = 2;  'h014: cmd = 3;  'h029: cmd = 4;
              'h16B: cmd = 1;  'h174: cmd = 2;
              default: cmd = 0;
            endcase
            if (cmd != 0 && !(m_hv && m_held == key)) begin
              exec = 1; m_hv = 1; m_held = key;
            end
          end
          pend.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (exec) begin
          if (cmd == 1) m_data[k] = m_rol(m_data[k]);
          if (cmd == 2) m_data[k] = m_ror(m_data[k]);
          if (cmd == 3) m_data[k] = m_rev(m_data[k]);
        end else if (tick) begin
          m_data[k] = m_dir ? m_rol(m_data[k]) : m_ror(m_data[k]);
        end
      end
      if (exec) begin
        if (cmd == 1) m_dir = 1;
        if (cmd == 2) m_dir = 0;
        if (cmd == 4) m_auto = !m_auto;
        if (cmd != 3 || tick) anchor = cyc + 1;
      end
      m_pulse = exec;
      cyc++;
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("data0",  32'(data0),  32'(m_data[0]));
      check("data1",  32'(data1),  32'(m_data[1]));
      check("auto0",  32'(auto0),  32'(m_auto));
      check("auto1",  32'(auto1),  32'(m_auto));
      check("dir0",   32'(dir0),   32'(m_dir));
      check("dir1",   32'(dir1),   32'(m_dir));
      check("pulse0", 32'(pulse0), 32'(m_pulse));
      check("pulse1", 32'(pulse1), 32'(m_pulse));
    end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic [7:0] b);
    done = 1'b1;
    data = b;
    @(posedge CLK);
    #2;
    done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; done = 1'b0; data = 8'h00;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("reset_data0", 32'(data0), 32'h01);
    check("reset_data1", 32'(data1), 32'h03);
    check("reset_auto",  32'(auto0), 32'h0);
    check("reset_dir",   32'(dir0),  32'h1);
    check("reset_pulse", 32'(pulse0), 32'h0);

    // Basic left, then release and right.
    strobe(8'h1D);
    check("left_data",  32'(data0),  32'h02);
    check("left_pulse", 32'(pulse0), 32'h1);
    idle(1);
    check("left_pulse_end", 32'(pulse0), 32'h0);
    strobe(8'hF0); strobe(8'h1D); strobe(8'h22);
    check("right_data", 32'(data0), 32'h01);
    check("right_dir",  32'(dir0),  32'h0);

    // Typematic repeats collapse to one command until released.
    strobe(8'h1D);
    check("typ1_data", 32'(data0), 32'h02);
    strobe(8'h1D);
    check("typ2_pulse", 32'(pulse0), 32'h0);
    strobe(8'h1D);
    check("typ3_data", 32'(data0), 32'h02);
    strobe(8'hF0); strobe(8'h1D); strobe(8'h1D);
    check("rel_left_data", 32'(data0), 32'h04);

    // Reverse and extended keys (second instance holds 8'h03).
    reset_pulse();
    strobe(8'h14);
    check("rev_data1", 32'(data1), 32'hC0);
    check("rev_data0", 32'(data0), 32'h80);
    strobe(8'hE0); strobe(8'h74);
    check("ext_right_data1", 32'(data1), 32'h60);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h74);
    strobe(8'hE0); strobe(8'h6B);
    check("ext_left_data1", 32'(data1), 32'hC0);
    check("ext_left_dir",   32'(dir1),  32'h1);

    // Auto-run stepping every AUTO_DIV cycles.
    reset_pulse();
    strobe(8'h29);
    check("auto_on", 32'(auto0), 32'h1);
    idle(4);
    check("auto_step1", 32'(data0), 32'h02);
    idle(4);
    check("auto_step2", 32'(data0), 32'h04);
    idle(4);
    check("auto_step3", 32'(data0), 32'h08);
    strobe(8'hF0); strobe(8'h29); strobe(8'h29);
    check("auto_off",        32'(auto0), 32'h0);
    check("auto_off_data",   32'(data0), 32'h08);
    idle(10);
    check("auto_frozen",     32'(data0), 32'h08);

    // Key lands on the tick cycle: one rotate, prescaler restarts.
    strobe(8'hF0); strobe(8'h29); strobe(8'h29);
    check("auto_on2", 32'(auto0), 32'h1);
    idle(3);
    check("pre_coll_data", 32'(data0), 32'h08);
    strobe(8'h1D);
    check("coll_data",  32'(data0),  32'h10);
    check("coll_pulse", 32'(pulse0), 32'h1);
    idle(3);
    check("coll_hold", 32'(data0), 32'h10);
    idle(1);
    check("coll_next_tick", 32'(data0), 32'h20);
    strobe(8'h29);
    check("auto_off2", 32'(auto0), 32'h0);

    // Reset after E0 discards the prefix: 6B is then an unmapped normal make.
    strobe(8'hE0);
    reset_pulse();
    strobe(8'h6B);
    check("rst_ext_data0", 32'(data0),  32'h01);
    check("rst_ext_pulse", 32'(pulse0), 32'h0);
    check("rst_ext_data1", 32'(data1),  32'h03);

    idle(2);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
